// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier dispatch block.
package mul_pkg;

    localparam int unsigned MUL_W     = 8;
    localparam int unsigned MUL_DEPTH = 4;
    localparam int unsigned MUL_LAT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    localparam int unsigned MUL_CNT_W = cnt_width(MUL_LAT);

endpackage

// File: rtl/mul_op_fifo.sv
// Operand-pair FIFO; count carries an extra MSB so full and empty differ.
module mul_op_fifo
    import mul_pkg::*;
#(
    parameter int unsigned DW    = 2 * MUL_W,
    parameter int unsigned DEPTH = MUL_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Shift-add multiplier; the load edge handles bit 0, product valid W cycles after write.
module seq_mul #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           write,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod
);

    logic [2*W-1:0] acc_q, mcand_q;
    logic [W-1:0]   mplier_q;

    assign prod = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (write) begin
            acc_q    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand_q  <= {{W{1'b0}}, a} << 1;
            mplier_q <= b >> 1;
        end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/mul_dispatch.sv
// Feeds queued operand pairs to seq_mul and returns products in order.
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int unsigned W           = MUL_W,
    parameter int unsigned DEPTH       = MUL_DEPTH,
    parameter int unsigned MUL_LATENCY = MUL_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           mul_write,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_prod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           busy
);

    localparam int unsigned CW = cnt_width(MUL_LATENCY);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           ov_q, ov_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [2*W-1:0] head;
    logic           full, empty, pop;

    mul_op_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (in_valid),
        .data_i ({in_a, in_b}),
        .pop_i  (pop),
        .head_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign in_ready  = !full;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_valid = ov_q;
    assign out_prod  = prod_q;
    assign busy      = (state_q != ST_IDLE) || !empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        ov_d      = ov_q;
        prod_d    = prod_q;
        pop       = 1'b0;
        mul_write = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    {a_d, b_d} = head;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mul_write = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MUL_LATENCY - 1)) begin
                    prod_d  = mul_prod;
                    ov_d    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    ov_d = 1'b0;
                    if (!empty) begin
                        pop      = 1'b1;
                        {a_d, b_d} = head;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench: mul_dispatch driving a real seq_mul.
module tb_mul_dispatch;

    localparam int W = 8;
    localparam int DEPTH = 4;
    localparam int LAT = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0, in_b = '0;
    logic           mul_write;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_prod;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_prod;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int seen144 = 0;
    logic [2*W-1:0] exp_q[$];

    mul_dispatch #(.W(W), .DEPTH(DEPTH), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mul_write(mul_write), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .busy(busy)
    );

    seq_mul #(.W(W)) u_mul (
        .clk(clk), .reset(reset), .write(mul_write),
        .a(mul_a), .b(mul_b), .prod(mul_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && mul_write) wr_cnt++;
    end

    // Output monitor: every handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (out_prod == 16'd144) seen144++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got %0d, expected none", out_prod);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if (out_prod !== e) begin
                    n_bad++;
                    $display("FAIL result: got %0d, expected %0d", out_prod, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e);
        int n;
        bit ok;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        ok = 0;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1;
            end
            n++;
            if (!ok) @(posedge clk);
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", (n < 400) ? 1 : 0, 1);
    endtask

    task automatic wait_ov(output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (!ok && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) ok = 1;
        end
        chk("out_valid_timeout", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int w0;
        int acc;
        bit ok;
        logic [2*W-1:0] hp;
        logic [W-1:0] ha, hb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_write", mul_write, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_out_prod", out_prod, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single job latency and one write pulse
        w0 = wr_cnt;
        send(8'd8, 8'd7, 16'd56);
        in_valid = 1'b0;
        acc_cyc = cyc;
        wait_ov(ok);
        chk("latency", cyc - acc_cyc, LAT + 2);
        drain();
        chk("write_pulses", wr_cnt - w0, 1);

        // back-to-back
        send(8'd8, 8'd7, 16'd56);
        send(8'd10, 8'd11, 16'd110);
        send(8'd255, 8'd255, 16'd65025);
        send(8'd0, 8'd5, 16'd0);
        drain();

        // capacity with consumer blocked, then stall stability
        out_ready = 1'b0;
        acc = 0;
        begin
            logic [W-1:0] ta [6] = '{8'd2, 8'd4, 8'd6, 8'd9, 8'd11, 8'd20};
            logic [W-1:0] tb [6] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd12, 8'd20};
            logic [2*W-1:0] te [6] = '{16'd6, 16'd20, 16'd42, 16'd81, 16'd132, 16'd400};
            for (int i = 0; i < 6; i++) begin
                in_a = ta[i];
                in_b = tb[i];
                in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) begin
                    exp_q.push_back(te[i]);
                    acc++;
                end
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        chk("accepted", acc, DEPTH + 1);
        chk("full_in_ready", in_ready, 0);
        wait_ov(ok);
        hp = out_prod;
        ha = mul_a;
        hb = mul_b;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            chk("stall_prod", out_prod, hp);
            chk("stall_valid", out_valid, 1);
            chk("stall_write", mul_write, 0);
            chk("stall_mul_a", mul_a, ha);
            chk("stall_mul_b", mul_b, hb);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_return", in_ready, 1);
        drain();

        // reset during WAIT
        send(8'd12, 8'd12, 16'd144);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_wait_out_valid", out_valid, 0);
        chk("rst_wait_mul_write", mul_write, 0);
        chk("rst_wait_in_ready", in_ready, 1);
        chk("rst_wait_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'd3, 8'd4, 16'd12);
        drain();

        // push and pop together with DEPTH-1 queued
        out_ready = 1'b0;
        send(8'd5, 8'd5, 16'd25);
        send(8'd6, 8'd6, 16'd36);
        send(8'd7, 8'd7, 16'd49);
        send(8'd8, 8'd8, 16'd64);
        in_valid = 1'b0;
        wait_ov(ok);
        chk("pp_count_before", dut.u_fifo.cnt_q, DEPTH - 1);
        in_a = 8'd9;
        in_b = 8'd10;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pp_in_ready", in_ready, 1);
        if (in_ready) exp_q.push_back(16'd90);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pp_count_after", dut.u_fifo.cnt_q, DEPTH - 1);
        chk("pp_in_ready_after", in_ready, 1);
        drain();

        // pointer wrap
        begin
            logic [W-1:0] wa [12] = '{1, 3, 15, 100, 200, 128, 7, 13, 255, 250, 16, 99};
            logic [W-1:0] wb [12] = '{2, 3, 16, 3, 200, 2, 9, 17, 1, 4, 16, 99};
            logic [2*W-1:0] we [12] = '{2, 9, 240, 300, 40000, 256, 63, 221, 255, 1000, 256, 9801};
            for (int i = 0; i < 3 * DEPTH; i++) send(wa[i], wb[i], we[i]);
        end
        drain();

        chk("no_144_seen", seen144, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
